// File: rtl/spi_ram_if.sv
// Frame/read-back bus between the SPI slave (master modport) and spi_ram_ctrl (slave modport).
interface spi_ram_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM fed by SPI frames; read data returns as a one-cycle tx strobe.
// Optional macro SPI_RAM_AUTOINC_EN: post-increment wr_addr after each write and rd_addr after each read.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256
) (
  input  logic     clk,
  input  logic     rst,
  spi_ram_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);

  if ((MEM_DEPTH < 4) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spi_ram_ctrl: MEM_DEPTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload;

  assign cmd     = cmd_e'(bus.rx_data[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = bus.rx_data[ADDR_SIZE-1:0];

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 mem_we;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    mem_we     = 1'b0;

    if (bus.rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload;
        CMD_WR_DATA: begin
          mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`endif
        end
        CMD_RD_ADDR: rd_addr_d = payload;
        CMD_RD_DATA: begin
          // A write on the previous edge is already in mem, so no bypass is needed here.
          tx_data_d  = mem[rd_addr_q];
          tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
          rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // NOTE: the memory array has no reset, so it maps onto plain RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_addr_q] <= payload;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed plus randomized bench for spi_ram_ctrl, checked against a frame-level memory model.
module tb_spi_ram_ctrl;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_ram_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

  spi_ram_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: memory as an associative array of written words only.
  int m_mem [int];
  int m_wr = 0;
  int m_rd = 0;
  int m_tx_data = 0;
  int m_tx_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input bit r, input bit v, input logic [9:0] d);
    int cmd;
    int pl;
    cmd = int'(d[9:8]);
    pl  = int'(d[7:0]);
    if (r) begin
      m_wr = 0; m_rd = 0; m_tx_data = 0; m_tx_valid = 0;
      return;
    end
    m_tx_valid = 0;
    if (!v) return;
    if (cmd == 0) m_wr = pl;
    else if (cmd == 1) begin
      m_mem[m_wr] = pl;
`ifdef SPI_RAM_AUTOINC_EN
      m_wr = (m_wr + 1) % MEM_DEPTH;
`endif
    end else if (cmd == 2) m_rd = pl;
    else begin
      m_tx_data  = m_mem.exists(m_rd) ? m_mem[m_rd] : -1;
      m_tx_valid = 1;
`ifdef SPI_RAM_AUTOINC_EN
      m_rd = (m_rd + 1) % MEM_DEPTH;
`endif
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then compare outputs against the model.
  task automatic step(input string tag, input bit r, input bit v, input logic [9:0] d);
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    model_apply(r, v, d);
    check({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(m_tx_valid));
    check({tag, ".tx_data"}, 32'(bus.tx_data), 32'(m_tx_data));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 10'h000);
  endtask

  initial begin
    logic [9:0] frame;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // 1. Reset with a valid read frame present; it must be discarded.
    step("rst0", 1'b1, 1'b1, 10'h3FF);
    step("rst1", 1'b1, 1'b1, 10'h3FF);
    check("rst.tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst.tx_data", 32'(bus.tx_data), 32'h00);

    // 2. Basic write then read.
    step("wr_addr", 1'b0, 1'b1, 10'h03A);
    step("wr_data", 1'b0, 1'b1, 10'h1A5);
    step("rd_addr", 1'b0, 1'b1, 10'h23A);
    step("rd_data", 1'b0, 1'b1, 10'h300);
    check("basic.tx_valid", 32'(bus.tx_valid), 32'h1);
    check("basic.tx_data", 32'(bus.tx_data), 32'hA5);
    idle("basic.after");
    check("basic.strobe_len", 32'(bus.tx_valid), 32'h0);
    check("basic.hold", 32'(bus.tx_data), 32'hA5);

    // 3. Frames with rx_valid low are ignored.
    for (int i = 0; i < 3; i++) step("invalid", 1'b0, 1'b0, 10'h1FF);
    check("invalid.tx_valid", 32'(bus.tx_valid), 32'h0);
    step("inv.rd_addr", 1'b0, 1'b1, 10'h23A);
    step("inv.rd_data", 1'b0, 1'b1, 10'h300);
    check("invalid.readback", 32'(bus.tx_data), 32'hA5);
    check("invalid.strobe", 32'(bus.tx_valid), 32'h1);
    idle("invalid.after");

    // 4. Write immediately followed by a read of the same word, then back-to-back reads.
    step("haz.wr_addr", 1'b0, 1'b1, 10'h010);
    step("haz.rd_addr", 1'b0, 1'b1, 10'h210);
    step("haz.wr_data", 1'b0, 1'b1, 10'h15C);
    step("haz.rd_data", 1'b0, 1'b1, 10'h300);
    check("hazard.tx_data", 32'(bus.tx_data), 32'h5C);
    idle("haz.gap");
`ifdef SPI_RAM_AUTOINC_EN
    step("b2b.wr_addr", 1'b0, 1'b1, 10'h011);
    step("b2b.wr0", 1'b0, 1'b1, 10'h15C);
    step("b2b.wr1", 1'b0, 1'b1, 10'h15C);
    step("b2b.rd_addr", 1'b0, 1'b1, 10'h211);
`endif
    step("b2b.rd0", 1'b0, 1'b1, 10'h300);
    check("b2b0.tx_valid", 32'(bus.tx_valid), 32'h1);
    check("b2b0.tx_data", 32'(bus.tx_data), 32'h5C);
    step("b2b.rd1", 1'b0, 1'b1, 10'h300);
    check("b2b1.tx_valid", 32'(bus.tx_valid), 32'h1);
    check("b2b1.tx_data", 32'(bus.tx_data), 32'h5C);
    idle("b2b.after");

    // 5. Reset coinciding with a read frame; memory survives.
    step("rst_mid", 1'b1, 1'b1, 10'h300);
    check("rst_mid.tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_mid.tx_data", 32'(bus.tx_data), 32'h00);
    step("ret.rd_addr", 1'b0, 1'b1, 10'h23A);
    step("ret.rd_data", 1'b0, 1'b1, 10'h300);
    check("retain.tx_data", 32'(bus.tx_data), 32'hA5);
    idle("ret.after");

    // 6. Repeated writes/reads: address wrap with auto-increment, overwrite without.
    step("ai.wr_addr", 1'b0, 1'b1, 10'h0FF);
    step("ai.wr0", 1'b0, 1'b1, 10'h111);
    step("ai.wr1", 1'b0, 1'b1, 10'h122);
    step("ai.rd_addr", 1'b0, 1'b1, 10'h2FF);
    step("ai.rd0", 1'b0, 1'b1, 10'h300);
`ifdef SPI_RAM_AUTOINC_EN
    check("ai.first", 32'(bus.tx_data), 32'h11);
`else
    check("ai.first", 32'(bus.tx_data), 32'h22);
`endif
    step("ai.rd1", 1'b0, 1'b1, 10'h300);
    check("ai.second", 32'(bus.tx_data), 32'h22);
    step("ai.reload", 1'b0, 1'b1, 10'h2FF);
    step("ai.rd_ff", 1'b0, 1'b1, 10'h300);
`ifdef SPI_RAM_AUTOINC_EN
    check("ai.mem_ff", 32'(bus.tx_data), 32'h11);
`else
    check("ai.mem_ff", 32'(bus.tx_data), 32'h22);
`endif
    idle("ai.after");

    // Randomized traffic; reads of unwritten words become writes instead.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit v;
      frame = 10'($urandom);
      v = ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 49) == 0);
      if (frame[9:8] == 2'b11 && !m_mem.exists(m_rd)) frame[9:8] = 2'b01;
      step("rand", r, v, frame);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
